neuron_weight_sequencer: RTL and testbench
==========================================

NEURON_WEIGHT_SEQUENCER -- requirements
Module: neuron_weight_sequencer

Interface
REQ-001 The block SHALL have parameter numWeight, default 3, meaning weights per neuron pass.
REQ-002 The block SHALL have parameter addressWidth, default 10, meaning weight-memory address width.
REQ-003 The block SHALL have parameter dataWidth, default 16, meaning input, weight and bias word width.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock, the block's only clock.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have port start  input  1  request to begin one neuron pass.
REQ-007 The block SHALL have ports in_valid  input  1 and in_data  input  dataWidth: the input-activation stream.
REQ-008 The block SHALL have port in_ready  output  1  activation accepted this cycle when in_valid=1.
REQ-009 The block SHALL have ports cfg_wen  input  1 and cfg_wdata  input  dataWidth: sequential weight load.
REQ-010 The block SHALL have ports mem_wen  output  1, mem_wadd  output  addressWidth and mem_win  output  dataWidth: weight-memory write port.
REQ-011 The block SHALL have ports mem_ren  output  1, mem_radd  output  addressWidth and mem_wout  input  dataWidth: weight-memory read port, one-cycle read latency.
REQ-012 The block SHALL have ports pair_valid  output  1, pair_x  output  dataWidth, pair_w  output  dataWidth and pair_last  output  1: aligned operand pair to the MAC.
REQ-013 The block SHALL have ports busy  output  1, done  output  1 (one-cycle pulse) and cfg_err  output  1 (one-cycle pulse).

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN and DONE (plus BIAS, see REQ-029).
REQ-015 In IDLE, start=1 SHALL move to RUN with read counter rd_cnt=0.
REQ-016 In IDLE, cfg_wen=1 without start SHALL drive mem_wen=1, mem_wadd=ld_ptr and mem_win=cfg_wdata in the same cycle (combinational) and increment ld_ptr, wrapping from numWeight-1 to 0.
REQ-017 In IDLE, if start and cfg_wen are both 1, start SHALL win, the write SHALL be dropped and cfg_err SHALL pulse for the next cycle.
REQ-018 In any state other than IDLE, cfg_wen=1 SHALL be dropped and cfg_err SHALL pulse for the next cycle.
REQ-019 in_ready SHALL be 1 only in RUN.
REQ-020 In RUN with in_valid=1, mem_ren=1 and mem_radd=rd_cnt SHALL be driven combinationally, in_data SHALL be registered, and rd_cnt SHALL increment.
REQ-021 One cycle after each accepted input, pair_valid SHALL be 1, pair_x SHALL carry the registered in_data, and pair_w SHALL equal mem_wout.
REQ-022 When input index numWeight-1 is accepted, the FSM SHALL go to DRAIN, and that input's pair SHALL carry pair_last=1.
REQ-023 DRAIN SHALL last one cycle and then go to DONE; DONE SHALL assert done=1 for one cycle and then go to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Gaps in in_valid during RUN SHALL stall with no pair_valid, and no timeout SHALL apply.
REQ-026 numWeight (numWeight+1 with the bias feature) SHALL be at most 2^addressWidth.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE with rd_cnt=0, ld_ptr=0 and pair_valid, pair_x, pair_last, done, cfg_err, busy and bias_valid all 0.
REQ-028 A reset during RUN or DRAIN SHALL abort the pass with no done and no further pair_valid; ld_ptr SHALL also reset.

Configuration
REQ-029 Macro NEURON_BIAS_EN SHALL enable the following bias behaviour.
- Adds output ports bias_valid (1 bit) and bias_data (dataWidth).
- Replaces DRAIN with BIAS: mem_ren=1 with mem_radd=numWeight.
- bias_valid=1 and bias_data=mem_wout one cycle after the BIAS read, coinciding with the DONE state.
- done follows one cycle after that; ld_ptr wraps at numWeight instead of numWeight-1.
REQ-030 Without NEURON_BIAS_EN, the bias ports and the BIAS state SHALL be absent and the behaviour SHALL be as in REQ-014 to REQ-025.

Verification
REQ-031 Load: cfg_wen three cycles with data 5, 7, 9 -> mem_wadd 0, 1, 2 and mem_win 5, 7, 9; a fourth write goes to address 0.
REQ-032 Pass: start, then in_data 1, 2, 3 back-to-back -> mem_radd 0, 1, 2; pair_x/pair_w (1,5), (2,7), (3,9), with pair_last on the third pair; done 2 cycles after the last input.
REQ-033 Stall: in_valid pattern 1,0,0,1,1 -> pairs only one cycle after each accepted input, and rd_cnt holds during the gaps.
REQ-034 Conflict: start and cfg_wen in the same IDLE cycle -> RUN entered, no mem_wen, cfg_err=1 next cycle; cfg_wen during RUN -> cfg_err as well.
REQ-035 Reset: rst asserted after the second accepted input -> all outputs 0 immediately, no done; a new start then reads from address 0.
REQ-036 Bias (NEURON_BIAS_EN, bias word 11 at address 3) -> after the third pair, mem_radd=3, then bias_valid=1 with bias_data=11, then done.

Source files
------------

// File: rtl/neuron_weight_sequencer.sv
// rtl/neuron_weight_sequencer.sv - weight load / fetch sequencer pairing activations with weights for a MAC
// Optional feature: define NEURON_BIAS_EN to fetch a bias word from address numWeight after each pass.
module neuron_weight_sequencer #(
  parameter int numWeight    = 3,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    in_ready,
  input  logic                    cfg_wen,
  input  logic [dataWidth-1:0]    cfg_wdata,
  output logic                    mem_wen,
  output logic [addressWidth-1:0] mem_wadd,
  output logic [dataWidth-1:0]    mem_win,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_radd,
  input  logic [dataWidth-1:0]    mem_wout,
  output logic                    pair_valid,
  output logic [dataWidth-1:0]    pair_x,
  output logic [dataWidth-1:0]    pair_w,
  output logic                    pair_last,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
`ifdef NEURON_BIAS_EN
  ,
  output logic                    bias_valid,
  output logic [dataWidth-1:0]    bias_data
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
`ifdef NEURON_BIAS_EN
  localparam logic [1:0] S_BIAS  = 2'd2;
`else
  localparam logic [1:0] S_DRAIN = 2'd2;
`endif
  localparam logic [1:0] S_DONE  = 2'd3;

  // Index of the final activation in a pass
  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);
`ifdef NEURON_BIAS_EN
  // The bias word lives just past the weights, so the loader covers one extra slot
  localparam logic [addressWidth-1:0] BIAS_ADDR = addressWidth'(numWeight);
  localparam logic [addressWidth-1:0] LD_LAST   = addressWidth'(numWeight);
`else
  localparam logic [addressWidth-1:0] LD_LAST   = addressWidth'(numWeight - 1);
`endif

  logic [1:0]              r_state;
  logic [addressWidth-1:0] r_rd_cnt;
  logic [addressWidth-1:0] r_ld_ptr;
  logic [dataWidth-1:0]    r_x;
  logic                    r_pair_valid;
  logic                    r_pair_last;
  logic                    r_cfg_err;

  logic w_idle;
  logic w_accept;
  logic w_last_in;
  logic w_load;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = (r_state == S_RUN) && in_valid;
  assign w_last_in = w_accept && (r_rd_cnt == LAST_IDX);
  // A start in the same cycle takes priority, so the write is dropped
  assign w_load    = w_idle && cfg_wen && !start;

  // Pass control: IDLE -> RUN -> DRAIN/BIAS -> DONE -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rd_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_rd_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_rd_cnt <= r_rd_cnt + addressWidth'(1);
            if (w_last_in) begin
`ifdef NEURON_BIAS_EN
              r_state <= S_BIAS;
`else
              r_state <= S_DRAIN;
`endif
            end
          end
        end
`ifdef NEURON_BIAS_EN
        S_BIAS:  r_state <= S_DONE;
`else
        S_DRAIN: r_state <= S_DONE;
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sequential weight-load pointer, wrapping over the weight (and bias) slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_ptr <= '0;
    end else if (w_load) begin
      if (r_ld_ptr == LD_LAST) begin
        r_ld_ptr <= '0;
      end else begin
        r_ld_ptr <= r_ld_ptr + addressWidth'(1);
      end
    end
  end

  // Activation stage: hold the accepted word so it lines up with the memory read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x          <= '0;
      r_pair_valid <= 1'b0;
      r_pair_last  <= 1'b0;
    end else begin
      r_pair_valid <= w_accept;
      r_pair_last  <= w_last_in;
      if (w_accept) begin
        r_x <= in_data;
      end
    end
  end

  // Any write that cannot be honoured is reported one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_wen && (!w_idle || start);
    end
  end

  // Weight-memory write port
  always_comb begin
    mem_wen  = w_load;
    mem_wadd = '0;
    mem_win  = '0;
    if (w_load) begin
      mem_wadd = r_ld_ptr;
      mem_win  = cfg_wdata;
    end
  end

  // Weight-memory read port: weights during RUN, bias word afterwards
  always_comb begin
    mem_ren  = 1'b0;
    mem_radd = '0;
    if (w_accept) begin
      mem_ren  = 1'b1;
      mem_radd = r_rd_cnt;
    end
`ifdef NEURON_BIAS_EN
    else if (r_state == S_BIAS) begin
      mem_ren  = 1'b1;
      mem_radd = BIAS_ADDR;
    end
`endif
  end

  assign in_ready   = (r_state == S_RUN);
  assign busy       = !w_idle;
  assign cfg_err    = r_cfg_err;
  assign pair_valid = r_pair_valid;
  assign pair_x     = r_x;
  assign pair_last  = r_pair_last;
  // Memory data is only meaningful in the cycle after a read
  assign pair_w     = r_pair_valid ? mem_wout : '0;

`ifdef NEURON_BIAS_EN
  logic r_done;

  // done trails the bias word by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
    end
  end

  assign done       = r_done;
  assign bias_valid = (r_state == S_DONE);
  assign bias_data  = bias_valid ? mem_wout : '0;
`else
  assign done       = (r_state == S_DONE);
`endif

endmodule

// File: tb/tb_neuron_weight_sequencer.sv
// tb/tb_neuron_weight_sequencer.sv - scoreboard bench for neuron_weight_sequencer
module tb_neuron_weight_sequencer;

  localparam int NW = 3;
  localparam int AW = 10;
  localparam int DW = 16;
`ifdef NEURON_BIAS_EN
  localparam int LDN = NW + 1;
`else
  localparam int LDN = NW;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          cfg_wen = 1'b0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          mem_wen;
  logic [AW-1:0] mem_wadd;
  logic [DW-1:0] mem_win;
  logic          mem_ren;
  logic [AW-1:0] mem_radd;
  logic [DW-1:0] mem_wout = '0;
  logic          pair_valid;
  logic [DW-1:0] pair_x;
  logic [DW-1:0] pair_w;
  logic          pair_last;
  logic          busy;
  logic          done;
  logic          cfg_err;
`ifdef NEURON_BIAS_EN
  logic          bias_valid;
  logic [DW-1:0] bias_data;
`endif

  neuron_weight_sequencer #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_wen(cfg_wen), .cfg_wdata(cfg_wdata),
    .mem_wen(mem_wen), .mem_wadd(mem_wadd), .mem_win(mem_win),
    .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_wout(mem_wout),
    .pair_valid(pair_valid), .pair_x(pair_x), .pair_w(pair_w), .pair_last(pair_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef NEURON_BIAS_EN
    , .bias_valid(bias_valid), .bias_data(bias_data)
`endif
  );

  always #5 clk = ~clk;

  // Environment: weight memory with one-cycle read latency
  logic [DW-1:0] tb_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wen) tb_mem[mem_wadd] <= mem_win;
    if (mem_ren) mem_wout <= tb_mem[mem_radd];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what has been loaded, where the loader points, and pass progress
  logic [DW-1:0] ref_w [0:LDN-1];
  int ld = 0;
  bit m_active = 0;
  int m_idx = 0;
  int m_idle_at = 0;

  typedef struct {
    int          c;
    int          ch;
    logic [31:0] a;
    logic [31:0] b;
    logic        l;
  } ev_t;
  ev_t sb[$];
  string ch_name [6] = '{"wr", "rd", "pair", "done", "cfg_err", "bias"};

  function automatic void push(input int c, input int ch, input logic [31:0] a,
                               input logic [31:0] b, input logic l);
    ev_t e;
    e.c = c; e.ch = ch; e.a = a; e.b = b; e.l = l;
    sb.push_back(e);
  endfunction

  // Monitor: every observed event must match an expected one scheduled for this cycle
  always @(negedge clk) begin : monitor
    logic        av;
    logic [31:0] aa;
    logic [31:0] ab;
    logic        al;
    int          idx;
    if (!rst) begin
      for (int ch = 0; ch < 6; ch++) begin
        av = 1'b0; aa = '0; ab = '0; al = 1'b0;
        case (ch)
          0: begin av = mem_wen; aa = 32'(mem_wadd); ab = 32'(mem_win); end
          1: begin av = mem_ren; aa = 32'(mem_radd); end
          2: begin av = pair_valid; aa = 32'(pair_x); ab = 32'(pair_w); al = pair_last; end
          3: av = done;
          4: av = cfg_err;
`ifdef NEURON_BIAS_EN
          5: begin av = bias_valid; ab = 32'(bias_data); end
`endif
          default: av = 1'b0;
        endcase
        idx = -1;
        foreach (sb[i]) if (sb[i].ch == ch && sb[i].c == cyc) idx = i;
        if (av || idx >= 0) begin
          n_cmp++;
          if (idx < 0) begin
            n_err++;
            $display("FAIL %s cyc=%0d unexpected event a=%0d b=%0d l=%0b", ch_name[ch], cyc, aa, ab, al);
          end else begin
            if (!av || aa != sb[idx].a || ab != sb[idx].b || al != sb[idx].l) begin
              n_err++;
              $display("FAIL %s cyc=%0d got v=%0b a=%0d b=%0d l=%0b want v=1 a=%0d b=%0d l=%0b",
                       ch_name[ch], cyc, av, aa, ab, al, sb[idx].a, sb[idx].b, sb[idx].l);
            end
            sb.delete(idx);
          end
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].c < cyc) begin
          n_cmp++; n_err++;
          $display("FAIL %s missing event due cyc=%0d", ch_name[sb[i].ch], sb[i].c);
          sb.delete(i);
        end
      end
    end
  end

  // One stimulus cycle; the model predicts the consequences of these inputs
  task automatic drive(input logic s, input logic v, input logic [DW-1:0] d,
                       input logic w, input logic [DW-1:0] wd);
    bit idle_now;
    @(posedge clk); #1;
    start = s; in_valid = v; in_data = d; cfg_wen = w; cfg_wdata = wd;
    idle_now = !m_active && (cyc >= m_idle_at);
    n_cmp++;
    if (in_ready !== m_active || busy !== !idle_now) begin
      n_err++;
      $display("FAIL state cyc=%0d in_ready=%0b busy=%0b want in_ready=%0b busy=%0b",
               cyc, in_ready, busy, m_active, !idle_now);
    end
    if (w) begin
      if (idle_now && !s) begin
        push(cyc, 0, 32'(ld), 32'(wd), 1'b0);
        ref_w[ld] = wd;
        ld = (ld + 1) % LDN;
      end else begin
        push(cyc + 1, 4, 0, 0, 1'b0);
      end
    end
    if (m_active) begin
      if (v) begin
        push(cyc, 1, 32'(m_idx), 0, 1'b0);
        push(cyc + 1, 2, 32'(d), 32'(ref_w[m_idx]), m_idx == NW - 1);
        if (m_idx == NW - 1) begin
          m_active = 0;
          m_idle_at = cyc + 3;
`ifdef NEURON_BIAS_EN
          push(cyc + 1, 1, 32'(NW), 0, 1'b0);
          push(cyc + 2, 5, 0, 32'(ref_w[NW]), 1'b0);
          push(cyc + 3, 3, 0, 0, 1'b0);
`else
          push(cyc + 2, 3, 0, 0, 1'b0);
`endif
        end
        m_idx++;
      end
    end else if (idle_now && s) begin
      m_active = 1;
      m_idx = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic load(input logic [DW-1:0] d);
    drive(1'b0, 1'b0, '0, 1'b1, d);
  endtask

  task automatic check_zero(input string tag);
    logic [DW*3+8:0] v;
    v = {pair_valid, pair_x, pair_w, pair_last, done, cfg_err, busy, in_ready, mem_wen, mem_ren};
`ifdef NEURON_BIAS_EN
    v[0] = v[0] | bias_valid;
`endif
    n_cmp++;
    if (v != '0) begin
      n_err++;
      $display("FAIL %s outputs not cleared: 0x%0h want 0", tag, v);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 0; in_valid = 0; cfg_wen = 0;
    #1 check_zero("reset_async");
    sb.delete();
    m_active = 0; m_idx = 0; m_idle_at = 0; ld = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_pass(input int valid_pct, input int wen_pct);
    int guard = 0;
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    while (m_active && guard < 300) begin
      drive(($urandom_range(99) < 5), ($urandom_range(99) < valid_pct), DW'($urandom),
            ($urandom_range(99) < wen_pct), DW'($urandom));
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL pass_timeout stuck in pass after %0d cycles want completion", guard);
      m_active = 0;
    end
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) tb_mem[i] = '0;
    for (int i = 0; i < LDN; i++) ref_w[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_zero("reset_init");
    @(posedge clk); #1;
    rst = 1'b0;

    // Load 5, 7, 9 (plus bias word 11)
    load(16'd5); load(16'd7); load(16'd9);
`ifdef NEURON_BIAS_EN
    load(16'd11);
`endif
    idle(1);

    // Back-to-back pass 1, 2, 3
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd1, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd2, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd3, 1'b0, '0);
    idle(4);

    // Loader wraps back to address 0
    load(16'd13);
    idle(1);

    // Stall pattern 1,0,0,1,1
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd21, 1'b0, '0);
    drive(1'b0, 1'b0, 16'd99, 1'b0, '0);
    drive(1'b0, 1'b0, 16'd98, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd22, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd23, 1'b0, '0);
    idle(4);

    // Start and cfg_wen together, then cfg_wen during RUN
    drive(1'b1, 1'b0, '0, 1'b1, 16'hAAAA);
    drive(1'b0, 1'b1, 16'd31, 1'b1, 16'hBBBB);
    drive(1'b0, 1'b1, 16'd32, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd33, 1'b0, '0);
    drive(1'b0, 1'b0, '0, 1'b1, 16'hCCCC);
    idle(4);

    // Reset after the second accepted input, then a fresh pass from address 0
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd41, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd42, 1'b0, '0);
    do_reset();
    idle(2);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd51, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd52, 1'b0, '0);
    drive(1'b0, 1'b1, 16'd53, 1'b0, '0);
    idle(4);

    // Randomized mix of loads and passes
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(1) == 0) begin
        for (int k = 0; k < int'($urandom_range(4, 1)); k++) begin
          drive(($urandom_range(99) < 10), 1'b0, '0, ($urandom_range(99) < 80), DW'($urandom));
          if (m_active) run_pass(70, 0);
        end
        idle(1);
      end else begin
        run_pass(int'($urandom_range(100, 30)), 10);
      end
    end

    idle(6);
    foreach (sb[i]) begin
      n_cmp++; n_err++;
      $display("FAIL %s never observed, due cyc=%0d", ch_name[sb[i].ch], sb[i].c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
